// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bus bundle for the load/store unit
interface load_store_unit_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BYTES = XLEN / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [XLEN-1:0]       req_wdata;

    logic                  resp_valid;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_fault;

    logic                  mem_req;
    logic                  mem_ack;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BYTES-1:0]      mem_wstrb;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN-1:0]       mem_rdata;

    // master: execute stage plus memory; slave: the load/store unit itself
    modport master (
        output req_valid, req_we, req_funct, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with lane alignment, extension and word-crossing split
module load_store_unit #(
    parameter int XLEN             = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int LW    = $clog2(XLEN);

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_SPLIT0, S_SPLIT1, S_RESP, S_FAULT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BYTES-1:0]      r_mem_wstrb;
    logic [XLEN-1:0]       r_mem_wdata;
    logic [BYTES-1:0]      r_wstrb_hi;
    logic [XLEN-1:0]       r_wdata_hi;
    logic [XLEN-1:0]       r_lo;
    logic [XLEN-1:0]       r_rdata;
    logic [3:0]            r_size;
    logic [OFS-1:0]        r_off;
    logic                  r_we;
    logic                  r_signed;

    logic [OFS-1:0]        w_off;
    logic [3:0]            w_size;
    logic [4:0]            w_end;
    logic                  w_cross;
    logic                  w_illegal;
    logic                  w_fault;
    logic [2*BYTES-1:0]    w_strb2;
    logic [2*XLEN-1:0]     w_wdata2;

    logic [XLEN-1:0]       w_rd_lo;
    logic [XLEN-1:0]       w_rd_hi;
    logic [XLEN-1:0]       w_merged;
    logic [6:0]            w_nbits;
    logic [XLEN-1:0]       w_keep;
    logic                  w_sign;
    logic [XLEN-1:0]       w_load;

    assign w_off   = bus.req_addr[OFS-1:0];
    assign w_size  = 4'd1 << bus.req_funct[1:0];
    assign w_end   = 5'(w_off) + 5'(w_size);
    assign w_cross = w_end > 5'(BYTES);
    assign w_fault = w_illegal || (w_cross && !ALLOW_MISALIGNED);

    // Both bus words viewed as one double-width lane field; the high half feeds SPLIT1.
    assign w_strb2  = ((((2*BYTES)'(1)) << w_size) - (2*BYTES)'(1)) << w_off;
    assign w_wdata2 = {{XLEN{1'b0}}, bus.req_wdata} << {w_off, 3'b000};

    always_comb begin
        w_illegal = 1'b1;
        case (bus.req_funct)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
            3'b011, 3'b110:                         w_illegal = (XLEN != 64);
            default:                                w_illegal = 1'b1;
        endcase
        if (bus.req_we && bus.req_funct[2]) begin
            w_illegal = 1'b1;
        end
    end

    // Merge then extend: the kept field is 8*size bits wide, sign taken from its top bit.
    assign w_rd_lo  = (r_state == S_SPLIT1) ? r_lo : bus.mem_rdata;
    assign w_rd_hi  = (r_state == S_SPLIT1) ? bus.mem_rdata : '0;
    assign w_merged = XLEN'({w_rd_hi, w_rd_lo} >> {r_off, 3'b000});
    assign w_nbits  = {r_size, 3'b000};
    assign w_keep   = (XLEN'(1) << w_nbits) - XLEN'(1);
    assign w_sign   = r_signed & w_merged[LW'(w_nbits - 7'd1)];
    assign w_load   = (w_merged & w_keep) | (~w_keep & {XLEN{w_sign}});

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (w_fault)      w_state_nxt = S_FAULT;
                    else if (w_cross) w_state_nxt = S_SPLIT0;
                    else              w_state_nxt = S_ACC;
                end
            end
            S_ACC:    if (bus.mem_ack) w_state_nxt = S_RESP;
            S_SPLIT0: if (bus.mem_ack) w_state_nxt = S_SPLIT1;
            S_SPLIT1: if (bus.mem_ack) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            S_FAULT:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_wstrb_hi  <= '0;
            r_wdata_hi  <= '0;
            r_lo        <= '0;
            r_rdata     <= '0;
            r_size      <= '0;
            r_off       <= '0;
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_size     <= w_size;
                r_off      <= w_off;
                r_we       <= bus.req_we;
                r_signed   <= ~bus.req_funct[2];
                r_wstrb_hi <= bus.req_we ? w_strb2[2*BYTES-1:BYTES] : '1;
                r_wdata_hi <= bus.req_we ? w_wdata2[2*XLEN-1:XLEN] : '0;
                if (w_fault) begin
                    r_rdata <= '0;
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= bus.req_we;
                    r_mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                    r_mem_wstrb <= bus.req_we ? w_strb2[BYTES-1:0] : '1;
                    r_mem_wdata <= bus.req_we ? w_wdata2[XLEN-1:0] : '0;
                end
            end
            if (r_state == S_SPLIT0 && bus.mem_ack) begin
                r_lo        <= bus.mem_rdata;
                r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(BYTES);
                r_mem_wstrb <= r_wstrb_hi;
                r_mem_wdata <= r_wdata_hi;
            end
            if ((r_state == S_ACC || r_state == S_SPLIT1) && bus.mem_ack) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_rdata   <= r_we ? '0 : w_load;
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) && !reset;
    assign bus.resp_valid = (r_state == S_RESP) || (r_state == S_FAULT);
    assign bus.resp_fault = (r_state == S_FAULT);
    assign bus.resp_rdata = r_rdata;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wstrb  = r_mem_wstrb;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
